// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multicycle multiply/divide unit
//   state_t  - controller states
//   booth_t  - radix-2 Booth operation select
package multdiv_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;
    localparam logic [DEF_WIDTH-1:0] INT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    typedef enum logic [1:0] {NOP, ADD, SUB} booth_t;
endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: start/operand/result bundle between the pipeline and the multiply/divide unit
//   master: drives ctrl_MULT, ctrl_DIV, data_operandA/B; receives result, exception, RDY, busy
//   slave : the unit side of the same signals
interface multdiv_ctrl_if import multdiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/add_sub32.sv
// add_sub32: WIDTH-bit ripple adder/subtractor built from full-adder cells
//   a, b, sub -> sum = sub ? a-b : a+b, cout (carry out of MSB), ovf (signed overflow)
module add_sub32 import multdiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH:0] c;
    assign c[0] = sub;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i] ^ sub), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
    end
    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full-adder cell
//   a, b, cin -> s, cout
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: multicycle signed Booth multiply / non-restoring divide on one shared adder
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   bus (slave)    - start pulses, operands in; result, exception, one-cycle RDY, busy out
module multdiv_ctrl import multdiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic           clock,
    input logic           reset,
    multdiv_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    booth_t           sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_q, res_d;
    logic             qm1_q, qm1_d, div_q, div_d, neg_q, neg_d, dz_q, dz_d;
    logic             exc_q, exc_d, oexc_q, oexc_d, rdy_q, rdy_d;
    logic [WIDTH-1:0] add_a, add_b, sum;
    logic             add_s, cout, ovf, last;
    logic [WIDTH:0]   t;
    add_sub32 #(.WIDTH(WIDTH)) u_add (.a(add_a), .b(add_b), .sub(add_s), .sum(sum), .cout(cout), .ovf(ovf));
    // hi/lo form {P_hi, P_lo} for multiply and {remainder, dividend->quotient} for divide
    always_comb begin
        sel   = {lo_q[0], qm1_q} == 2'b01 ? ADD : {lo_q[0], qm1_q} == 2'b10 ? SUB : NOP;
        add_a = state_q == FIX ? '0 : state_q == DIV ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : hi_q;
        add_b = state_q == FIX ? lo_q : m_q;
        add_s = state_q == FIX || (state_q == DIV ? !hi_q[WIDTH-1] : sel == SUB);
        // true sign of the 33-bit Booth sum comes from the overflow flag
        t     = sel == NOP ? {hi_q[WIDTH-1], hi_q} : {sum[WIDTH-1] ^ ovf, sum};
        last  = cnt_q == CNT_W'(WIDTH - 1);
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        div_d   = div_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        exc_d   = exc_q;
        res_d   = res_q;
        oexc_d  = oexc_q;
        rdy_d   = 1'b0;
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            state_d = bus.ctrl_MULT ? MUL : DIV;
            div_d   = !bus.ctrl_MULT;
            cnt_d   = '0;
            hi_d    = '0;
            qm1_d   = 1'b0;
            lo_d    = bus.ctrl_MULT ? bus.data_operandB :
                      bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
            m_d     = bus.ctrl_MULT ? bus.data_operandA :
                      bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
            neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz_d    = bus.data_operandB == '0;
        end else begin
            case (state_q)
                MUL: begin
                    hi_d    = t[WIDTH:1];
                    lo_d    = {t[0], lo_q[WIDTH-1:1]};
                    qm1_d   = lo_q[0];
                    cnt_d   = last ? '0 : cnt_q + 1'b1;
                    state_d = last ? FIX : MUL;
                end
                DIV: begin
                    // carry out of the remainder update is set exactly when the new remainder is non-negative
                    hi_d    = sum;
                    lo_d    = {lo_q[WIDTH-2:0], cout};
                    cnt_d   = last ? '0 : cnt_q + 1'b1;
                    state_d = last ? FIX : DIV;
                end
                FIX: begin
                    lo_d    = !div_q ? lo_q : dz_q ? '0 : neg_q ? sum : lo_q;
                    exc_d   = div_q ? dz_q || (!neg_q && lo_q[WIDTH-1]) : hi_q != {WIDTH{lo_q[WIDTH-1]}};
                    state_d = DONE;
                end
                DONE: begin
                    res_d   = lo_q;
                    oexc_d  = exc_q;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            exc_q   <= 1'b0;
            res_q   <= '0;
            oexc_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            exc_q   <= exc_d;
            res_q   <= res_d;
            oexc_q  <= oexc_d;
            rdy_q   <= rdy_d;
        end
    end
    assign bus.data_result    = res_q;
    assign bus.data_exception = oexc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = state_q != IDLE || rdy_q;
endmodule
